// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Holds the FSM state encoding, the grant encoding and the counter-width helper.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation guard: counts data grants taken while a fetch is waiting and
// decides whether the fetch port wins the next arbitration.
module mem_arb_starve_ctr
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic gnt_stb,
    input  gnt_t gnt_sel,
    output logic fetch_wins
);

    localparam int CW = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_reg;

    // Data normally wins a tie; a fetch that has watched STARVE_MAX data grants goes next.
    assign fetch_wins = i_req && (!d_req || (cnt_reg == CNT_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (gnt_stb) begin
            if (gnt_sel == GNT_I) begin
                cnt_reg <= '0;
            end else if (i_req && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and load/store
// ports, one transaction in flight, fixed accept-to-rvalid latency MEM_LAT+2.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int WC_W = cnt_width(MEM_LAT - 1);

    arb_state_t          state_reg;
    gnt_t                gnt_reg;
    gnt_t                gnt_next;
    logic [WC_W-1:0]     wait_cnt_reg;
    logic                tx_we_reg;
    logic                fetch_wins;
    logic                accept;
    logic                store_next;
    logic [BE_W-1:0]     be_next;

    logic                mem_en_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [BE_W-1:0]     mem_be_reg;
    logic                i_rvalid_reg;
    logic                d_rvalid_reg;
    logic [DATA_W-1:0]   i_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .d_req      (d_req),
        .gnt_stb    (accept),
        .gnt_sel    (gnt_next),
        .fetch_wins (fetch_wins)
    );

    // Ready is gated by rst so nothing is offered while reset is asserted.
    assign accept     = rst && (state_reg == ST_IDLE) && (i_req || d_req);
    assign gnt_next   = fetch_wins ? GNT_I : GNT_D;
    assign store_next = (gnt_next == GNT_D) && d_we;
    assign i_ready    = accept && (gnt_next == GNT_I);
    assign d_ready    = accept && (gnt_next == GNT_D);

    // Only stores narrow the byte enables; every read fetches the full word.
    for (genvar gi = 0; gi < BE_W; gi++) begin : gen_be
        assign be_next[gi] = store_next ? d_be[gi] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= GNT_I;
            wait_cnt_reg  <= '0;
            tx_we_reg     <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            i_rvalid_reg  <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
        end else begin
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_ISSUE;
                        gnt_reg       <= gnt_next;
                        tx_we_reg     <= store_next;
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= store_next;
                        mem_addr_reg  <= (gnt_next == GNT_D) ? d_addr : i_addr;
                        mem_wdata_reg <= (gnt_next == GNT_D) ? d_wdata : '0;
                        mem_be_reg    <= be_next;
                    end
                end
                ST_ISSUE: begin
                    state_reg    <= ST_WAIT;
                    wait_cnt_reg <= WC_W'(MEM_LAT - 1);
                    mem_en_reg   <= 1'b0;
                    mem_we_reg   <= 1'b0;
                end
                ST_WAIT: begin
                    // Last WAIT cycle is exactly when the memory presents its data.
                    if (wait_cnt_reg == '0) begin
                        state_reg <= ST_RESP;
                        if (gnt_reg == GNT_I) begin
                            i_rvalid_reg <= 1'b1;
                            i_rdata_reg  <= mem_rdata;
                        end else begin
                            d_rvalid_reg <= 1'b1;
                            d_rdata_reg  <= tx_we_reg ? '0 : mem_rdata;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - WC_W'(1);
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign i_rvalid  = i_rvalid_reg;
    assign d_rvalid  = d_rvalid_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two environments (MEM_LAT=1 and MEM_LAT=3), each with
// a memory model, a schedule-based reference model, directed tests and random traffic.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input int lat, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lat%0d %s: got 0x%0h, expected 0x%0h", lat, name, act, exp);
        end
    endtask

    // Content of a never-written word: a simple function of its address.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : gen_env
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic        rst = 1'b1;
        logic        done = 1'b0;
        logic        i_req, i_ready, i_rvalid;
        logic [31:0] i_addr, i_rdata;
        logic        d_req, d_we, d_ready, d_rvalid;
        logic [31:0] d_addr, d_wdata, d_rdata;
        logic [3:0]  d_be;
        logic        mem_en, mem_we, busy;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        logic [3:0]  mem_be;

        logic        pv [LAT];
        logic [31:0] pd [LAT];
        logic [31:0] phys_mem [logic [31:0]];
        logic [31:0] ref_mem  [logic [31:0]];

        mem_port_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LAT    (LAT),
            .STARVE_MAX (STARVE)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req),
            .i_addr    (i_addr),
            .i_ready   (i_ready),
            .i_rvalid  (i_rvalid),
            .i_rdata   (i_rdata),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_be      (d_be),
            .d_ready   (d_ready),
            .d_rvalid  (d_rvalid),
            .d_rdata   (d_rdata),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_be    (mem_be),
            .mem_rdata (mem_rdata),
            .busy      (busy)
        );

        // Synchronous memory: data for an enable in cycle t is valid only in cycle t+LAT.
        assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBADD_A7A0;

        initial begin : memory
            for (int k = 0; k < LAT; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= 32'h0;
            end
            phys_mem[32'h4]  = 32'h0020_0093;
            phys_mem[32'h40] = 32'h1234_5678;
            forever begin
                @(posedge clk);
                for (int k = LAT - 1; k > 0; k--) begin
                    pv[k] <= pv[k-1];
                    pd[k] <= pd[k-1];
                end
                pv[0] <= mem_en;
                if (mem_en && mem_we)
                    phys_mem[mem_addr] = merge(phys_mem.exists(mem_addr) ? phys_mem[mem_addr]
                                               : init_val(mem_addr), mem_wdata, mem_be);
                pd[0] <= phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : init_val(mem_addr);
            end
        end

        // Reference: a transaction accepted in cycle A issues at A+1, responds at A+2+LAT,
        // and the arbiter is free again from A+3+LAT.
        initial begin : model
            int          cyc, acc_cyc, scnt;
            logic        tx_d, tx_we, busy_e, fw, ir_e, dr_e;
            logic [31:0] tx_addr, tx_wdata, resp, exp_ird, exp_drd;
            logic [3:0]  tx_be;
            cyc = 0; acc_cyc = -1000; scnt = 0;
            tx_d = 1'b0; tx_we = 1'b0; tx_addr = 0; tx_wdata = 0; tx_be = 0;
            resp = 0; exp_ird = 0; exp_drd = 0;
            ref_mem[32'h4]  = 32'h0020_0093;
            ref_mem[32'h40] = 32'h1234_5678;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    chk(LAT, "reset_outputs", 64'(|{i_ready, i_rvalid, i_rdata, d_ready, d_rvalid,
                        d_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy}), 64'(0));
                    acc_cyc = -1000; scnt = 0; exp_ird = 0; exp_drd = 0;
                end else begin
                    busy_e = (cyc > acc_cyc) && (cyc <= acc_cyc + LAT + 2);
                    fw     = i_req && (!d_req || scnt >= STARVE);
                    ir_e   = !busy_e && fw;
                    dr_e   = !busy_e && d_req && !fw;
                    if (cyc == acc_cyc + 1) begin
                        resp = tx_we ? 32'h0 : (ref_mem.exists(tx_addr) ? ref_mem[tx_addr]
                                                : init_val(tx_addr));
                        if (tx_we)
                            ref_mem[tx_addr] = merge(ref_mem.exists(tx_addr) ? ref_mem[tx_addr]
                                                     : init_val(tx_addr), tx_wdata, tx_be);
                    end
                    if (cyc == acc_cyc + LAT + 2) begin
                        if (tx_d) exp_drd = resp;
                        else      exp_ird = resp;
                    end
                    chk(LAT, "i_ready", 64'(i_ready), 64'(ir_e));
                    chk(LAT, "d_ready", 64'(d_ready), 64'(dr_e));
                    chk(LAT, "busy", 64'(busy), 64'(busy_e));
                    chk(LAT, "mem_en", 64'(mem_en), 64'(cyc == acc_cyc + 1));
                    chk(LAT, "i_rvalid", 64'(i_rvalid), 64'((cyc == acc_cyc + LAT + 2) && !tx_d));
                    chk(LAT, "d_rvalid", 64'(d_rvalid), 64'((cyc == acc_cyc + LAT + 2) && tx_d));
                    chk(LAT, "i_rdata", 64'(i_rdata), 64'(exp_ird));
                    chk(LAT, "d_rdata", 64'(d_rdata), 64'(exp_drd));
                    if (cyc == acc_cyc + 1) begin
                        chk(LAT, "mem_we", 64'(mem_we), 64'(tx_we));
                        chk(LAT, "mem_be", 64'(mem_be), 64'(tx_be));
                        chk(LAT, "mem_addr", 64'(mem_addr), 64'(tx_addr));
                        if (tx_we) chk(LAT, "mem_wdata", 64'(mem_wdata), 64'(tx_wdata));
                    end
                    if (ir_e || dr_e) begin
                        acc_cyc  = cyc;
                        tx_d     = dr_e;
                        tx_we    = dr_e && d_we;
                        tx_addr  = dr_e ? d_addr : i_addr;
                        tx_wdata = d_wdata;
                        tx_be    = (dr_e && d_we) ? d_be : 4'hF;
                        if (ir_e) scnt = 0;
                        else if (i_req && scnt < STARVE) scnt++;
                    end
                end
                cyc++;
            end
        end

        initial begin : stim
            int   k, nbusy, n, c, j, r, cnt;
            logic ai, ad;
            i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
            #1 rst = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;

            // Single fetch from 0x4.
            @(posedge clk); #1;
            i_req = 1; i_addr = 32'h4;
            @(negedge clk); chk(LAT, "fetch_ready", 64'(i_ready), 64'(1));
            @(posedge clk); #1; i_req = 0;
            @(negedge clk); chk(LAT, "fetch_issue", 64'({mem_en, mem_addr}), {31'b0, 1'b1, 32'h4});
            k = 1;
            do begin @(negedge clk); k++; end while (!i_rvalid && k < 20);
            chk(LAT, "fetch_latency", 64'(k), 64'(LAT + 2));
            chk(LAT, "fetch_data", 64'(i_rdata), 64'(32'h0020_0093));

            // Store with partial byte enables.
            @(posedge clk); #1;
            d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
            @(negedge clk); chk(LAT, "store_ready", 64'(d_ready), 64'(1));
            @(posedge clk); #1; d_req = 0; d_we = 0;
            @(negedge clk);
            chk(LAT, "store_issue", 64'({mem_en, mem_we, mem_be}), 64'(6'b11_0011));
            chk(LAT, "store_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
            k = 1;
            do begin @(negedge clk); k++; end while (!d_rvalid && k < 20);
            chk(LAT, "store_latency", 64'(k), 64'(LAT + 2));
            chk(LAT, "store_rdata", 64'(d_rdata), 64'(0));

            // Load from 0x40, counting busy cycles up to and including RESP.
            @(posedge clk); #1;
            d_req = 1; d_addr = 32'h40;
            @(negedge clk); chk(LAT, "load_ready_idle", 64'({d_ready, busy}), 64'(2'b10));
            @(posedge clk); #1; d_req = 0;
            k = 0; nbusy = 0;
            do begin @(negedge clk); k++; nbusy += int'(busy); end while (!d_rvalid && k < 20);
            chk(LAT, "load_latency", 64'(k), 64'(LAT + 2));
            chk(LAT, "load_busy_cycles", 64'(nbusy), 64'(LAT + 2));
            chk(LAT, "load_data", 64'(d_rdata), 64'(32'h1234_5678));
            @(negedge clk); chk(LAT, "load_busy_after", 64'(busy), 64'(0));

            // Both ports requesting: four data grants, then the fetch.
            @(posedge clk); #1;
            i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h100; d_addr = 32'h80;
            n = 0; c = 0;
            while (n < 10 && c < 200) begin
                @(negedge clk);
                ai = i_ready; ad = d_ready;
                if (ai || ad) begin
                    chk(LAT, "arb_order", 64'(ad), 64'(n % 5 != 4));
                    n++;
                end
                @(posedge clk); #1;
                if (ai) i_addr = i_addr + 32'd4;
                if (ad) d_addr = d_addr + 32'd4;
                c++;
            end
            i_req = 0; d_req = 0;
            chk(LAT, "arb_grants", 64'(n), 64'(10));

            // Back-to-back fetches 0x0, 0x4, 0x8.
            repeat (LAT + 4) @(posedge clk);
            #1;
            i_req = 1; i_addr = 32'h0; j = 0; r = 0; c = 0;
            while ((j < 3 || r < 3) && c < 60) begin
                @(negedge clk);
                if (i_rvalid && r < 3) begin
                    chk(LAT, "b2b_rvalid_cycle", 64'(c), 64'(r * (LAT + 3) + LAT + 2));
                    r++;
                end
                ai = i_ready && (j < 3);
                if (ai) begin
                    chk(LAT, "b2b_accept_cycle", 64'(c), 64'(j * (LAT + 3)));
                    j++;
                end
                @(posedge clk); #1;
                if (ai) begin
                    i_addr = i_addr + 32'd4;
                    if (j == 3) i_req = 0;
                end
                c++;
            end
            chk(LAT, "b2b_count", 64'(j + r), 64'(6));

            // Reset asserted while a load to 0x100 sits in WAIT.
            repeat (LAT + 4) @(posedge clk);
            #1;
            d_req = 1; d_we = 0; d_addr = 32'h100;
            @(negedge clk); chk(LAT, "rst_load_ready", 64'(d_ready), 64'(1));
            @(posedge clk); #1; d_req = 0;
            @(posedge clk); #1; rst = 1'b0;
            @(negedge clk);
            chk(LAT, "rst_mid_wait", 64'({busy, mem_en, d_rvalid, d_rdata, i_rdata[15:0]}), 64'(0));
            chk(LAT, "rst_mem_addr", 64'(mem_addr), 64'(0));
            @(posedge clk); #1; rst = 1'b1;
            cnt = 0;
            repeat (LAT + 6) begin @(negedge clk); cnt += int'(d_rvalid); end
            chk(LAT, "rst_no_rvalid", 64'(cnt), 64'(0));

            // Random traffic; requesters hold their request stable until accepted.
            for (int t = 0; t < 600; t++) begin
                @(negedge clk);
                ai = i_ready; ad = d_ready;
                @(posedge clk); #1;
                if (!i_req || ai) begin
                    i_req = ($urandom_range(0, 2) != 0);
                    i_addr = 32'($urandom_range(0, 31) * 4);
                end else if ($urandom_range(0, 15) == 0) begin
                    i_req = 0;
                end
                if (!d_req || ad) begin
                    d_req = ($urandom_range(0, 2) != 0);
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = 32'($urandom_range(0, 31) * 4);
                    d_wdata = $urandom;
                    d_be = 4'($urandom_range(0, 15));
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req = 0;
                end
            end
            i_req = 0; d_req = 0;
            repeat (LAT + 4) @(posedge clk);
            done = 1'b1;
        end
    end

    initial begin : summary
        int waited;
        waited = 0;
        while (!(gen_env[0].done && gen_env[1].done) && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 20000) begin
            checks++;
            failures++;
            $display("FAIL timeout: done=%0b%0b, required 11", gen_env[1].done, gen_env[0].done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port.
- Sits between the datapath and the unified memory.
- Keeps one transaction in flight at a time.
- Data accesses have priority over fetches; a starvation guard ensures fetches are eventually served.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MEM_LAT, 1, cycles from memory enable to valid mem_rdata; must be ≥1.
- STARVE_MAX, 4, consecutive data grants after which a pending fetch wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_ready  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid, one-cycle pulse.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  load/store request.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid or store complete, one-cycle pulse.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rst=0, async):
  - FSM→IDLE, starvation counter=0.
  - All outputs 0.
  - In-flight transaction dropped; no rvalid is produced for it.
- FSM states:
  - IDLE: i_ready/d_ready are combinational, only in IDLE. Leave IDLE to ISSUE when a request is accepted.
  - ISSUE: one cycle, then go to WAIT.
  - WAIT: down-counter loaded with MEM_LAT-1 on entry; when it reaches 0, go to RESP.
  - RESP: one cycle, then go to IDLE.
- Arbitration in IDLE:
  - If d_req and i_req are both high and starve_cnt<STARVE_MAX: grant data.
  - If both are high and starve_cnt==STARVE_MAX: grant fetch.
  - If only one is requesting: grant that one.
  - Exactly one ready is asserted per cycle; none when there is no request.
- Starvation counter (saturating at STARVE_MAX):
  - Increments on each data grant while i_req=1.
  - Clears on a fetch grant.
  - Holds otherwise.
- Accept (cycle A, the IDLE cycle with ready=1):
  - Grant source, address, we, wdata and be are registered.
  - Requesters hold req/addr/wdata stable until they see ready.
- ISSUE (cycle A+1):
  - mem_en=1, registered.
  - Fetch: mem_we=0, mem_be=all ones.
  - Data: mem_we=d_we, mem_be=d_we ? d_be : all ones.
  - mem_en=0 in every other state.
- Response:
  - mem_rdata is sampled at cycle A+1+MEM_LAT (the last WAIT cycle) into the granted port's rdata register.
  - Granted rvalid is high in RESP, cycle A+2+MEM_LAT.
  - Fixed accept-to-rvalid latency = MEM_LAT+2.
  - Stores pulse d_rvalid as completion; d_rdata is then 0.
  - rdata registers hold their last value between responses; the non-granted port's rdata is unchanged.
- Throughput: the next accept is possible in the cycle after RESP. Back-to-back period = MEM_LAT+3 cycles.
- Requests arriving in non-IDLE states are not accepted and wait; no queuing.
- A request dropped before acceptance has no effect.
- Addresses pass through unchanged; the arbiter does no alignment checking.

Decomposition:
- Shared package/header (riscv_mem_pkg):
  - FSM state encoding (IDLE/ISSUE/WAIT/RESP).
  - Grant encoding (GNT_I, GNT_D).
  - Default STARVE_MAX and MEM_LAT constants.
- One sub-module: mem_arb_starve_ctr.
  - Contains the saturating starvation counter and priority-select logic.
  - Inputs: i_req, d_req, grant strobe.
  - Outputs: fetch_wins.

Test Plan:
- Reset: rst=0 mid-WAIT of a load to 0x100 → all outputs 0 immediately; after release, no d_rvalid ever appears for that load.
- Single fetch, MEM_LAT=1: i_req, i_addr=0x0000_0004 at cycle 0, mem model returns 0x0020_0093 → i_ready at cycle 0, mem_en/mem_addr=0x4 at cycle 1, i_rvalid with i_rdata=0x0020_0093 at cycle 3.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011 → mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF in ISSUE; d_rvalid with d_rdata=0 at cycle 3.
- Simultaneous requests: i_req and d_req both held high, STARVE_MAX=4 → grant order D,D,D,D,I, then repeats; no fetch waits more than 4 data grants.
- Latency parameter: MEM_LAT=3, load from 0x40 returning 0x1234_5678 → d_rvalid at cycle 5 with that data; busy high cycles 1–5.
- Back-to-back fetches, MEM_LAT=1: i_req held high with addresses 0x0, 0x4, 0x8 → accepts at cycles 0, 4, 8; i_rvalid at 3, 7, 11.
